// File: rtl/shot_render_pkg.sv
// Shared screen geometry, erase colour and FSM encoding
// for the bullet sprite renderer.
package shot_render_pkg;

   localparam int XW  = 8;
   localparam int YW  = 7;
   localparam int CW  = 3;
   localparam int DXW = 2;
   localparam int DYW = 3;

   localparam int SCR_X_MAX = 159;
   localparam int SCR_Y_MAX = 119;

   localparam logic [CW-1:0] BG_COLOUR_DEF = 3'b000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ERASE = 3'd1,
      S_DRAW  = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/sprite_scanner.sv
// Row-major dx/dy walker over one sprite; exposes the offset
// that will be current after the next edge.
module sprite_scanner
   import shot_render_pkg::*;
#(
   parameter int W = 1,
   parameter int H = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           i_start,
   input  logic           i_step,
   output logic [DXW-1:0] o_ndx,
   output logic [DYW-1:0] o_ndy,
   output logic           o_last
);

   localparam logic [DXW-1:0] DX_LAST = DXW'(W - 1);
   localparam logic [DYW-1:0] DY_LAST = DYW'(H - 1);

   logic [DXW-1:0] r_dx;
   logic [DYW-1:0] r_dy;
   logic           w_row_end;

   assign w_row_end = (r_dx == DX_LAST);
   assign o_last    = w_row_end && (r_dy == DY_LAST);

   always_comb begin
      o_ndx = r_dx;
      o_ndy = r_dy;
      if (i_start) begin
         o_ndx = '0;
         o_ndy = '0;
      end else if (i_step) begin
         if (w_row_end) begin
            o_ndx = '0;
            o_ndy = r_dy + 1'b1;
         end else begin
            o_ndx = r_dx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dx <= '0;
         r_dy <= '0;
      end else begin
         r_dx <= o_ndx;
         r_dy <= o_ndy;
      end
   end

endmodule

// File: rtl/shot_renderer.sv
// Turns shot-controller position updates into erase/draw
// pixel writes on the shared VGA plot port, then paces.
module shot_renderer
   import shot_render_pkg::*;
#(
   parameter int            SPRITE_W    = 1,
   parameter int            SPRITE_H    = 4,
   parameter int            HOLD_CYCLES = 833333,
   parameter logic [CW-1:0] BG_COLOUR   = BG_COLOUR_DEF,
   parameter int            X_MAX       = SCR_X_MAX,
   parameter int            Y_MAX       = SCR_Y_MAX
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          drawEn,
   input  logic          clearEn,
   input  logic [XW-1:0] bulletX,
   input  logic [YW-1:0] bulletY,
   input  logic [CW-1:0] colour,
   output logic          busy,
   output logic          done,
   output logic [XW-1:0] vgaX,
   output logic [YW-1:0] vgaY,
   output logic [CW-1:0] vgaColour,
   output logic          plot
);

   localparam int HCW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
   localparam logic [HCW-1:0] HOLD_LAST =
      HCW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [XW:0] X_LIM = (XW + 1)'(X_MAX);
   localparam logic [YW:0] Y_LIM = (YW + 1)'(Y_MAX);

   state_e r_state, w_nstate;

   logic [XW-1:0]  r_newX, w_nNewX, r_lastX, w_nLastX;
   logic [YW-1:0]  r_newY, w_nNewY, r_lastY, w_nLastY;
   logic [CW-1:0]  r_newC, w_nNewC;
   logic           r_lastValid, w_nLastValid;
   logic           r_isDraw, w_nIsDraw;
   logic [HCW-1:0] r_hold, w_nHold;

   logic           r_busy, r_done, r_plot;
   logic [XW-1:0]  r_vgaX;
   logic [YW-1:0]  r_vgaY;
   logic [CW-1:0]  r_vgaC;

   logic           w_start, w_step, w_last, w_scan;
   logic [DXW-1:0] w_ndx;
   logic [DYW-1:0] w_ndy;
   logic [XW-1:0]  w_baseX;
   logic [YW-1:0]  w_baseY;
   logic [CW-1:0]  w_pixC;
   logic [XW:0]    w_px;
   logic [YW:0]    w_py;

   sprite_scanner #(
      .W (SPRITE_W),
      .H (SPRITE_H)
   ) u_scan (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_start),
      .i_step  (w_step),
      .o_ndx   (w_ndx),
      .o_ndy   (w_ndy),
      .o_last  (w_last)
   );

   always_comb begin
      w_nstate     = r_state;
      w_start      = 1'b0;
      w_step       = 1'b0;
      w_nNewX      = r_newX;
      w_nNewY      = r_newY;
      w_nNewC      = r_newC;
      w_nLastX     = r_lastX;
      w_nLastY     = r_lastY;
      w_nLastValid = r_lastValid;
      w_nIsDraw    = r_isDraw;
      w_nHold      = r_hold;
      unique case (r_state)
         S_IDLE: begin
            if (drawEn) begin
               w_nIsDraw = 1'b1;
               w_nNewX   = bulletX;
               w_nNewY   = bulletY;
               w_nNewC   = colour;
               w_start   = 1'b1;
               w_nstate  = r_lastValid ? S_ERASE : S_DRAW;
            end else if (clearEn) begin
               w_nIsDraw = 1'b0;
               w_start   = r_lastValid;
               w_nstate  = r_lastValid ? S_ERASE : S_DONE;
            end
         end
         S_ERASE: begin
            if (!w_last) begin
               w_step = 1'b1;
            end else if (r_isDraw) begin
               w_start  = 1'b1;
               w_nstate = S_DRAW;
            end else begin
               w_nLastValid = 1'b0;
               w_nstate     = S_DONE;
            end
         end
         S_DRAW: begin
            if (!w_last) begin
               w_step = 1'b1;
            end else begin
               w_nLastX     = r_newX;
               w_nLastY     = r_newY;
               w_nLastValid = (r_newC != BG_COLOUR);
               w_nstate     = (HOLD_CYCLES > 0) ? S_HOLD : S_DONE;
            end
         end
         S_HOLD: begin
            if (r_hold == HOLD_LAST) begin
               w_nHold  = '0;
               w_nstate = S_DONE;
            end else begin
               w_nHold = r_hold + 1'b1;
            end
         end
         S_DONE:  w_nstate = S_IDLE;
         default: w_nstate = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each pixel
   // appears in the same cycle as the state that owns it.
   always_comb begin
      w_scan  = (w_nstate == S_ERASE) || (w_nstate == S_DRAW);
      w_baseX = (w_nstate == S_ERASE) ? r_lastX : w_nNewX;
      w_baseY = (w_nstate == S_ERASE) ? r_lastY : w_nNewY;
      w_pixC  = (w_nstate == S_ERASE) ? BG_COLOUR : w_nNewC;
      w_px    = {1'b0, w_baseX} + (XW + 1)'(w_ndx);
      w_py    = {1'b0, w_baseY} + (YW + 1)'(w_ndy);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_newX      <= '0;
         r_newY      <= '0;
         r_newC      <= '0;
         r_lastX     <= '0;
         r_lastY     <= '0;
         r_lastValid <= 1'b0;
         r_isDraw    <= 1'b0;
         r_hold      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_plot      <= 1'b0;
         r_vgaX      <= '0;
         r_vgaY      <= '0;
         r_vgaC      <= '0;
      end else begin
         r_state     <= w_nstate;
         r_newX      <= w_nNewX;
         r_newY      <= w_nNewY;
         r_newC      <= w_nNewC;
         r_lastX     <= w_nLastX;
         r_lastY     <= w_nLastY;
         r_lastValid <= w_nLastValid;
         r_isDraw    <= w_nIsDraw;
         r_hold      <= w_nHold;
         r_busy      <= (w_nstate != S_IDLE);
         r_done      <= (w_nstate == S_DONE);
         r_plot      <= w_scan && (w_px <= X_LIM) && (w_py <= Y_LIM);
         r_vgaX      <= w_scan ? w_px[XW-1:0] : '0;
         r_vgaY      <= w_scan ? w_py[YW-1:0] : '0;
         r_vgaC      <= w_scan ? w_pixC : '0;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign plot      = r_plot;
   assign vgaX      = r_vgaX;
   assign vgaY      = r_vgaY;
   assign vgaColour = r_vgaC;

endmodule

// File: tb/tb_shot_renderer.sv
// Randomised check of two shot_renderer builds (1- and 2-wide
// sprites) against a per-request pixel-trace model.
module tb_shot_renderer;

   localparam int HOLD = 2;
   localparam int SH   = 4;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       drawEn  = 1'b0;
   logic       clearEn = 1'b0;
   logic [7:0] bulletX = '0;
   logic [6:0] bulletY = '0;
   logic [2:0] colour  = '0;

   logic       busy [2];
   logic       done [2];
   logic       plot [2];
   logic [7:0] vgaX [2];
   logic [6:0] vgaY [2];
   logic [2:0] vgaC [2];

   int checks = 0;
   int errors = 0;

   bit m_lv = 1'b0;
   int m_lx = 0;
   int m_ly = 0;

   int e_len  [2];
   bit e_plot [2][64];
   bit e_done [2][64];
   int e_x    [2][64];
   int e_y    [2][64];
   int e_c    [2][64];

   always #5 clk = ~clk;

   shot_renderer #(
      .SPRITE_W (1), .SPRITE_H (SH), .HOLD_CYCLES (HOLD)
   ) u0 (
      .clk (clk), .reset (reset),
      .drawEn (drawEn), .clearEn (clearEn),
      .bulletX (bulletX), .bulletY (bulletY), .colour (colour),
      .busy (busy[0]), .done (done[0]),
      .vgaX (vgaX[0]), .vgaY (vgaY[0]),
      .vgaColour (vgaC[0]), .plot (plot[0])
   );

   shot_renderer #(
      .SPRITE_W (2), .SPRITE_H (SH), .HOLD_CYCLES (HOLD)
   ) u1 (
      .clk (clk), .reset (reset),
      .drawEn (drawEn), .clearEn (clearEn),
      .bulletX (bulletX), .bulletY (bulletY), .colour (colour),
      .busy (busy[1]), .done (done[1]),
      .vgaX (vgaX[1]), .vgaY (vgaY[1]),
      .vgaColour (vgaC[1]), .plot (plot[1])
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void add_cyc(int i, bit p, int x, int y,
                                   int c, bit dn);
      int k;
      k = e_len[i];
      e_plot[i][k] = p;
      e_done[i][k] = dn;
      e_x[i][k]    = x;
      e_y[i][k]    = y;
      e_c[i][k]    = c;
      e_len[i]     = k + 1;
   endfunction

   function automatic void scan_px(int i, int bx, int by, int c);
      int w;
      w = (i == 0) ? 1 : 2;
      for (int dy = 0; dy < SH; dy++)
         for (int dx = 0; dx < w; dx++)
            add_cyc(i, (bx + dx <= 159) && (by + dy <= 119),
                    bx + dx, by + dy, c, 1'b0);
   endfunction

   function automatic void build(bit is_draw, int x, int y, int c);
      for (int i = 0; i < 2; i++) begin
         e_len[i] = 0;
         if (m_lv) scan_px(i, m_lx, m_ly, 0);
         if (is_draw) begin
            scan_px(i, x, y, c);
            for (int h = 0; h < HOLD; h++)
               add_cyc(i, 1'b0, 0, 0, 0, 1'b0);
         end
         add_cyc(i, 1'b0, 0, 0, 0, 1'b1);
      end
      if (is_draw) begin
         m_lv = (c != 0);
         m_lx = x;
         m_ly = y;
      end else begin
         m_lv = 1'b0;
      end
   endfunction

   task automatic run_req(input bit d, input bit cl, input int x,
                          input int y, input int c, input int pulse,
                          input string tag);
      int maxl, minl, pat;
      string t;
      build(d, x, y, c);
      maxl = (e_len[0] > e_len[1]) ? e_len[0] : e_len[1];
      minl = (e_len[0] < e_len[1]) ? e_len[0] : e_len[1];
      pat  = (pulse <= minl - 1) ? pulse : -1;
      @(negedge clk);
      drawEn  = d;
      clearEn = cl;
      bulletX = x[7:0];
      bulletY = y[6:0];
      colour  = c[2:0];
      @(posedge clk);
      #1;
      drawEn  = 1'b0;
      clearEn = 1'b0;
      for (int k = 0; k <= maxl; k++) begin
         for (int i = 0; i < 2; i++) begin
            t = $sformatf("%s u%0d c%0d", tag, i, k + 1);
            if (k < e_len[i]) begin
               chk({t, " busy"}, busy[i], 1);
               chk({t, " done"}, done[i], e_done[i][k]);
               chk({t, " plot"}, plot[i], e_plot[i][k]);
               if (e_plot[i][k]) begin
                  chk({t, " x"}, vgaX[i], e_x[i][k]);
                  chk({t, " y"}, vgaY[i], e_y[i][k]);
                  chk({t, " col"}, vgaC[i], e_c[i][k]);
               end
            end else if (k == e_len[i]) begin
               chk({t, " idle busy"}, busy[i], 0);
               chk({t, " idle done"}, done[i], 0);
               chk({t, " idle plot"}, plot[i], 0);
            end
         end
         if (k == pat) begin
            drawEn  = 1'b1;
            clearEn = 1'($urandom);
            bulletX = 8'($urandom);
            bulletY = 7'($urandom);
            colour  = 3'($urandom);
         end else begin
            drawEn  = 1'b0;
            clearEn = 1'b0;
         end
         if (k < maxl) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      int r, x, y;
      #12;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst u%0d busy", i), busy[i], 0);
         chk($sformatf("rst u%0d done", i), done[i], 0);
         chk($sformatf("rst u%0d plot", i), plot[i], 0);
         chk($sformatf("rst u%0d x", i), vgaX[i], 0);
         chk($sformatf("rst u%0d y", i), vgaY[i], 0);
         chk($sformatf("rst u%0d col", i), vgaC[i], 0);
      end
      @(negedge clk);
      reset = 1'b0;

      run_req(1, 0, 40, 100, 7, -1, "draw1");
      run_req(1, 0, 40, 95, 7, -1, "draw2");
      run_req(0, 1, 40, 95, 0, -1, "clear1");
      run_req(0, 1, 40, 95, 0, -1, "clear2");
      run_req(1, 0, 159, 118, 5, -1, "edge");
      run_req(0, 1, 0, 0, 0, -1, "clear3");
      run_req(1, 0, 20, 30, 3, 2, "middraw");
      run_req(1, 1, 60, 60, 6, -1, "both");
      run_req(1, 0, 80, 50, 2, -1, "prerst");

      @(negedge clk);
      drawEn  = 1'b1;
      bulletX = 8'd10;
      bulletY = 7'd10;
      colour  = 3'd4;
      @(posedge clk);
      #1;
      drawEn = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("erase u%0d busy", i), busy[i], 1);
         chk($sformatf("erase u%0d plot", i), plot[i], 1);
      end
      #2;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("arst u%0d busy", i), busy[i], 0);
         chk($sformatf("arst u%0d plot", i), plot[i], 0);
         chk($sformatf("arst u%0d done", i), done[i], 0);
      end
      @(negedge clk);
      reset = 1'b0;
      m_lv  = 1'b0;
      run_req(1, 0, 10, 10, 4, -1, "postrst");

      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 9);
         x = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255)
                                         : $urandom_range(0, 159);
         y = ($urandom_range(0, 3) == 0) ? $urandom_range(112, 127)
                                         : $urandom_range(0, 119);
         run_req(r < 7, r >= 5, x, y, $urandom_range(0, 7),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1,
                 $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shot_renderer.md
Name: shot_renderer

Overview:
- Consumes the bullet position, colour and draw strobe from the shot controller and turns each update into VGA pixel writes.
- For each update, erases the previously drawn bullet sprite, draws the new one, then holds for a pacing interval.
- Returns a one-cycle done pulse that drives the shot controller's "position updated" input, which releases its WAIT state.
- Sits between the shot controller and the shared VGA plot interface.

Parameters:
- SPRITE_W, 1, bullet sprite width in pixels (1..4)
- SPRITE_H, 4, bullet sprite height in pixels (1..8)
- HOLD_CYCLES, 833333, idle cycles after drawing before done (motion pacing; 0 allowed)
- BG_COLOUR, 3'b000, colour used for erase
- X_MAX, 159, last visible column
- Y_MAX, 119, last visible row

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- drawEn  in  1  single-cycle request: erase old sprite, draw sprite at bulletX/bulletY
- clearEn  in  1  single-cycle request: erase old sprite only (collision, top reached)
- bulletX  in  8  sprite top-left column
- bulletY  in  7  sprite top-left row
- colour  in  3  sprite colour
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of each accepted request
- vgaX  out  8  pixel column
- vgaY  out  7  pixel row
- vgaColour  out  3  pixel colour
- plot  out  1  pixel write strobe

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE; busy=0, done=0, plot=0, vgaX=0, vgaY=0, vgaColour=0; lastValid=0; hold counter=0.
- Reset mid-operation aborts immediately. No further plots are issued. Pixels already written stay on screen.
- States: IDLE, ERASE, DRAW, HOLD, DONE.
- IDLE:
  - drawEn=1: latch bulletX/bulletY/colour into newX/newY/newC. Next state is ERASE if lastValid, else DRAW.
  - clearEn=1 (drawEn=0): next state is ERASE if lastValid, else DONE.
  - drawEn and clearEn together: drawEn wins.
- Requests arriving while busy are ignored (not queued).
- ERASE:
  - Scans the sprite at lastX/lastY, one pixel per cycle, with vgaColour=BG_COLOUR.
  - Then goes to DRAW for a draw request, or DONE for a clear request. A clear request also sets lastValid=0.
- DRAW:
  - Scans the sprite at newX/newY, one pixel per cycle, with vgaColour=newC.
  - On the last pixel: lastX/lastY <= newX/newY; lastValid <= (newC != BG_COLOUR).
  - Next state is HOLD if HOLD_CYCLES>0, else DONE.
- HOLD: counts HOLD_CYCLES cycles, then goes to DONE.
- DONE: done=1 for exactly one cycle, then returns to IDLE.
- Scan order: row-major (dy outer 0..SPRITE_H-1, dx inner 0..SPRITE_W-1). vgaX=baseX+dx, vgaY=baseY+dy.
- Output timing: vgaX/vgaY/vgaColour/plot are registered and change with the state.
- Clipping:
  - Pixel sums are computed one bit wider than the port.
  - Any pixel with x>X_MAX or y>Y_MAX still consumes its cycle but has plot=0.
  - No wrap-around onto the opposite screen edge.
- Latency, with drawEn sampled at edge 0 and N=SPRITE_W*SPRITE_H:
  - The first plot is in cycle 1.
  - done is asserted in cycle 1 + E + N + HOLD_CYCLES, where E = N if lastValid, else 0.
  - A clear request with lastValid=0 pulses done in cycle 1.
- plot and done are never high in the same cycle.
- busy is high from cycle 1 through the done cycle inclusive.

Decomposition:
- Package shot_render_pkg holds:
  - screen constants: X_MAX, Y_MAX, coordinate widths
  - BG_COLOUR
  - state encoding: IDLE, ERASE, DRAW, HOLD, DONE (3-bit)
- Sub-module sprite_scanner:
  - dx/dy counters with start input and last-pixel flag.
  - Instantiated once and restarted for each ERASE and DRAW phase.

Test Plan:
- Reset, then drawEn with X=40, Y=100, colour=111, HOLD_CYCLES=2 -> 4 plots at (40,100..103) colour 111 in cycles 1-4; done in cycle 7; no erase plots.
- Repeat drawEn with X=40, Y=95 -> 4 plots at (40,100..103) colour 000, then 4 at (40,95..98) colour 111; done in cycle 11.
- clearEn after a draw at (40,95) -> 4 erase plots at (40,95..98) colour 000, then done. A second clearEn -> done in cycle 1 with zero plots.
- drawEn at X=159, Y=118, SPRITE_W=2 -> only x=159, y=118 and y=119 plot. Clipped pixels have plot=0 but still consume cycles; done timing is unchanged.
- drawEn pulsed again mid-DRAW, plus drawEn and clearEn asserted together in IDLE -> the mid-DRAW pulse is ignored; the simultaneous case runs as a draw.
- reset asserted asynchronously during ERASE -> plot, busy and done drop to 0 immediately. The next drawEn draws without erasing (lastValid=0).
